adder: RTL and testbench



---
 rtl/mlp_fixed_pkg.sv | 18 +
 rtl/sm_add_core.sv | 42 ++++
 rtl/adder.sv | 49 ++++
 tb/tb_adder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mlp_fixed_pkg.sv
// Shared fixed-point definitions for the MLP datapath: signed-magnitude words
// with a sign bit on top and an unsigned magnitude below it.
package mlp_fixed_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned FRAC     = 17;
  localparam int unsigned SIGN_BIT = WIDTH - 1;

  localparam logic [WIDTH-2:0] MAG_MAX = 31'h7FFFFFFF;

  typedef struct packed {
    logic            sign;
    logic [WIDTH-2:0] mag;
  } sm_t;

  localparam sm_t SM_ZERO = '{sign: 1'b0, mag: '0};

endpackage

// File: rtl/sm_add_core.sv
// Combinational signed-magnitude adder: compare, add/subtract, saturate,
// and canonicalise zero to +0.
module sm_add_core
  import mlp_fixed_pkg::*;
(
  input  sm_t  a,
  input  sm_t  b,
  output sm_t  result,
  output logic ovf
);

  logic [WIDTH-1:0] sum;
  logic             a_ge_b;

  assign sum    = {1'b0, a.mag} + {1'b0, b.mag};
  assign a_ge_b = (a.mag >= b.mag);

  // Select add or subtract path, then force any zero magnitude to +0.
  always_comb begin
    result = SM_ZERO;
    ovf    = 1'b0;
    if (a.sign == b.sign) begin
      result.sign = a.sign;
      if (sum[SIGN_BIT]) begin
        result.mag = MAG_MAX;
        ovf        = 1'b1;
      end else begin
        result.mag = sum[WIDTH-2:0];
      end
    end else if (a_ge_b) begin
      result.sign = a.sign;
      result.mag  = a.mag - b.mag;
    end else begin
      result.sign = b.sign;
      result.mag  = b.mag - a.mag;
    end
    if (result.mag == '0) begin
      result.sign = 1'b0;
    end
  end

endmodule

// File: rtl/adder.sv
// Registered signed-magnitude adder: one pair per clock, one-cycle latency,
// saturating on same-sign overflow.
module adder
  import mlp_fixed_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic             ovf
);

  // The core works on the shared sm_t word; reject configurations it cannot hold.
  if (WIDTH != $bits(sm_t) || FRAC >= WIDTH) begin : g_bad_cfg
    $error("adder: WIDTH must match sm_t and FRAC must be below WIDTH");
  end

  sm_t  sum;
  logic sum_ovf;

  sm_add_core u_core (
    .a      (sm_t'(a)),
    .b      (sm_t'(b)),
    .result (sum),
    .ovf    (sum_ovf)
  );

  // Capture the sum when a pair is accepted; hold c/ovf otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      c         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c   <= sum;
        ovf <= sum_ovf;
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: integer reference model, per-cycle compare,
// directed literal vectors and randomized traffic.
module tb_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] c;
  logic        out_valid;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  adder #(.WIDTH(32), .FRAC(17)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: convert to signed integers, add, clamp to +/-MAX, re-encode.
  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    longint vx, vy, s, m;
    logic   o;
    logic [31:0] r;
    vx = x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    vy = y[31] ? -longint'(y[30:0]) : longint'(y[30:0]);
    s  = vx + vy;
    o  = 1'b0;
    if (s > 64'sd2147483647)  begin s = 64'sd2147483647;  o = 1'b1; end
    if (s < -64'sd2147483647) begin s = -64'sd2147483647; o = 1'b1; end
    m = (s < 0) ? -s : s;
    r = {(s < 0), m[30:0]};
    return {o, r};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Model of the registered outputs, updated on the same edge as the DUT.
  logic [31:0] exp_c = '0;
  logic        exp_ovf = 1'b0;
  logic        exp_valid = 1'b0;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    logic [32:0] r;
    if (rst) begin
      exp_c = '0; exp_ovf = 1'b0; exp_valid = 1'b0; model_live = 1'b1;
    end else begin
      exp_valid = in_valid;
      if (in_valid) begin
        r = ref_add(a, b);
        exp_c = r[31:0];
        exp_ovf = r[32];
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("cyc_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      check("cyc_c",     c,                  exp_c);
      check("cyc_ovf",   {31'b0, ovf},       {31'b0, exp_ovf});
    end
  end

  // Apply one pair, step one edge, check literal expectations.
  task automatic pair(input string name, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] ec, input logic eo);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    check({name, "_c"},   c, ec);
    check({name, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    check({name, "_vld"}, {31'b0, out_valid}, 32'd1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w = {w[31], 31'(w[15:0])};
      1: w = {w[31], 31'h7FFFFFFF - 31'(w[7:0])};
      2: w = {w[31], 31'd0};
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [32:0] m;
    logic [31:0] x, y, last_c;

    // Pin the reference model against hand-computed values.
    m = ref_add(32'h0006487E, 32'h00056FC2); check("model_pi_e", m[31:0], 32'h000BB840);
    m = ref_add(32'h00000000, 32'h80000000); check("model_zero", m[31:0], 32'h00000000);
    m = ref_add(32'hFFFFFFFF, 32'h80000001); check("model_negsat", {m[31:1], m[32]}, 32'hFFFFFFFF);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_c", c, 32'h0);
    check("reset_vld", {31'b0, out_valid}, 32'd0);
    check("reset_ovf", {31'b0, ovf}, 32'd0);
    rst = 1'b0;

    // Directed vectors, issued back-to-back.
    pair("pi_e",      32'h0006487E, 32'h00056FC2, 32'h000BB840, 1'b0);
    pair("signzero",  32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
    pair("mix1",      32'h80020000, 32'h00060000, 32'h00040000, 1'b0);
    pair("mix2",      32'h00020000, 32'h80060000, 32'h80040000, 1'b0);
    pair("cancel",    32'h00030000, 32'h80030000, 32'h00000000, 1'b0);
    pair("negsum",    32'h80020000, 32'h80040000, 32'h80060000, 1'b0);
    pair("possat",    32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1);
    pair("negsat",    32'hFFFFFFFF, 32'h80000001, 32'hFFFFFFFF, 1'b1);
    pair("negzeros",  32'h80000000, 32'h80000000, 32'h00000000, 1'b0);
    pair("after_sat", 32'h00010000, 32'h00010000, 32'h00020000, 1'b0);

    // Idle: valid drops, c/ovf hold.
    a = 32'h12345678; b = 32'h01010101; in_valid = 1'b0;
    @(posedge clk); #1;
    check("hold_vld", {31'b0, out_valid}, 32'd0);
    check("hold_c",   c, 32'h00020000);
    @(posedge clk); #1;
    check("hold_c2",  c, 32'h00020000);

    // Reset mid-stream with a valid pair present.
    a = 32'h00050000; b = 32'h00010000; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_c",   c, 32'h0);
    check("rst_mid_vld", {31'b0, out_valid}, 32'd0);
    check("rst_mid_ovf", {31'b0, ovf}, 32'd0);
    rst = 1'b0;
    pair("post_rst",  32'h00050000, 32'h80010000, 32'h00040000, 1'b0);

    // Randomized traffic checked by the per-cycle compare process.
    for (int unsigned i = 0; i < 3000; i++) begin
      x = rand_word();
      y = rand_word();
      if ($urandom_range(0, 7) == 0) y = {~x[31], x[30:0]};
      a = x; b = y;
      in_valid = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end

    // Final hold check after the random run.
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    last_c = exp_c;
    a = $urandom; b = $urandom;
    @(posedge clk); #1;
    check("final_hold", c, last_c);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
